lcd_stream_ctrl: RTL and testbench
==================================

# lcd_stream_ctrl

Parametrised write-only controller for HD44780-compatible character LCDs in 8-bit bus mode. It runs the power-up and init sequence on its own, then accepts characters over a valid/ready stream and drives the LCD bus (`data`, `enable`, `rw`, `rs`) with programmable setup, pulse and gap timing. It tracks the cursor across a ROWS x COLS panel, handles line wrap and newline, and accepts a clear request. It sits between any text-producing logic and the LCD pins, replacing hard-coded message sequencers.

## Interface
- `SETUP_CYCLES`, default 2: cycles `data`/`rs` are stable before `enable` rises (at least 1).
- `PULSE_CYCLES`, default 4: cycles `enable` is high (at least 1).
- `GAP_CYCLES`, default 40: cycles after `enable` falls before the next transaction, for ordinary commands and data (at least 1).
- `CLEAR_CYCLES`, default 1600: replaces `GAP_CYCLES` after a 0x01 (clear) transaction.
- `POWERUP_CYCLES`, default 15000: idle cycles after reset before the first init command.
- `COLS`, default 16: characters per row (1..40).
- `ROWS`, default 2: 1 or 2 only; any other value is a compile-time error.
- `clk` input 1: single clock; everything is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `char_valid` input 1: a character is offered.
- `char_data` input 8: the character code; 0x0A means newline, and every other value is written as-is.
- `char_ready` output 1: the controller can take a character or clear request this cycle.
- `clear_req` input 1: request to clear the display; sampled only while `char_ready`=1.
- `init_done` output 1: high once the init sequence completes; stays high until reset.
- `data` output 8: LCD DB7..DB0.
- `enable` output 1: LCD E strobe.
- `rw` output 1: LCD R/W. Held at 0; the block never reads.
- `rs` output 1: LCD RS; 0 selects instruction, 1 selects data.

## Operation
- Reset values: `data`=0x00, `enable`=0, `rw`=0, `rs`=0, `char_ready`=0, `init_done`=0. The cursor is at row 0, col 0 and all counters are cleared.
- Top FSM states: POWERUP → INIT → READY ⇄ BUSY.
  - POWERUP counts `POWERUP_CYCLES`, then moves to INIT.
  - INIT issues four instructions in order:
    - function set: 0x38 when ROWS=2, 0x30 when ROWS=1;
    - display on, cursor on, blink on: 0x0F;
    - clear: 0x01, followed by the `CLEAR_CYCLES` gap;
    - entry mode increment: 0x06.
  - After INIT, `init_done` goes to 1 and the FSM enters READY.
- Bus transaction, a sub-FSM with states SETUP → PULSE → GAP:
  - SETUP: `data`/`rs` are loaded and held for `SETUP_CYCLES`.
  - PULSE: `enable`=1 for `PULSE_CYCLES`.
  - GAP: `enable`=0 for `GAP_CYCLES`, or `CLEAR_CYCLES` if `data`=0x01.
  - `data` and `rs` stay unchanged from SETUP through the end of GAP.
- READY: `char_ready`=1. If `clear_req` and `char_valid` are both high, the clear wins and the character is not consumed; `char_ready` is low on the next cycle, so the producer keeps the character offered.
  - clear: issue 0x01 with `rs`=0; the cursor goes to (0,0).
  - Printable character (not 0x0A): issue `char_data` with `rs`=1, then col+1.
    - If col was COLS-1: col becomes 0, row becomes (row+1) mod ROWS, and a set-address instruction is issued straight away, before READY.
  - Newline 0x0A: no data write. col becomes 0, row becomes (row+1) mod ROWS, and the set-address instruction is issued.
  - Set-address value is 0x80 | base, where base is 0x00 for row 0 and 0x40 for row 1. With ROWS=1 every wrap goes to 0x80.
- BUSY covers the accepted transaction plus any set-address it triggers; `char_ready`=0 throughout BUSY.
- Counter widths come from $clog2 of the largest timing parameter. Every count is exact; no off-by-one slack is allowed.
- Reset mid-operation: all outputs return to their reset values at once, and the full POWERUP/INIT sequence restarts.

## Timing
- Accept edge A is the edge where `char_valid`/`clear_req` and `char_ready` are sampled high.
  - `data`/`rs` take the new values on edge A, and `char_ready` falls on edge A.
- `enable` rises on edge A+SETUP_CYCLES and falls on edge A+SETUP_CYCLES+PULSE_CYCLES.
- The transaction ends at T = A+SETUP_CYCLES+PULSE_CYCLES+GAP (GAP is `GAP_CYCLES` or `CLEAR_CYCLES`).
  - If a set-address follows, it starts its own SETUP on edge T.
  - Otherwise `char_ready` rises on edge T.
- Throughput with no wrap is one character per SETUP_CYCLES+PULSE_CYCLES+GAP_CYCLES cycles.
- First INIT command: `data`=0x38 on edge POWERUP_CYCLES after reset release.

## Test plan
All scenarios use SETUP=1, PULSE=1, GAP=2, CLEAR=5, POWERUP=3, COLS=4, ROWS=2.
- Reset, then idle:
  - expect `enable` pulses with `data` 0x38, 0x0F, 0x01, 0x06 in that order, `rs`=0 and `rw`=0;
  - the gap after 0x01 is 5 cycles;
  - `init_done` and `char_ready` rise together after the 0x06 gap.
- Stream "Hi!" with `char_valid` held high:
  - three `rs`=1 writes of 0x48, 0x69, 0x21;
  - `enable` high for 1 cycle each, and accepts 4 cycles apart.
- Send 5 characters "ABCDE":
  - after 'D', the next write is `rs`=0 with 0xC0, before 'E' is accepted;
  - 'E' is then written with `rs`=1.
- Newline then 'x' from (row 1, col 2):
  - 0x0A produces only `rs`=0 0x80 (no data write);
  - 'x' lands at row 0 col 0.
- `clear_req`=1 and `char_valid`=1 ('Z') on the same cycle:
  - the 0x01 write happens and the following gap is 5 cycles;
  - 'Z' is accepted after that and written at (0,0).
- Assert `rst_n`=0 while `enable`=1:
  - `enable`, `data` and `init_done` go to 0 immediately;
  - after release, the full init sequence repeats.

Source files
------------

// File: rtl/lcd_stream_ctrl_if.sv
// Character stream and LCD pin bundle for lcd_stream_ctrl.
// The controller connects through the slave modport; the text producer uses master.
interface lcd_stream_ctrl_if;
   logic       char_valid;
   logic [7:0] char_data;
   logic       char_ready;
   logic       clear_req;
   logic       init_done;
   logic [7:0] data;
   logic       enable;
   logic       rw;
   logic       rs;

   modport master (
      output char_valid, char_data, clear_req,
      input  char_ready, init_done, data, enable, rw, rs
   );

   modport slave (
      input  char_valid, char_data, clear_req,
      output char_ready, init_done, data, enable, rw, rs
   );
endinterface

// File: rtl/lcd_stream_ctrl.sv
// Write-only HD44780 8-bit bus controller: power-up/init sequencing, then a
// character stream with cursor tracking, line wrap, newline and clear.
//
// top state   | meaning
// POWERUP     | waiting POWERUP_CYCLES after reset before touching the panel
// INIT        | issuing function set, display on, clear, entry mode
// READY       | char_ready high, waiting for a character or clear request
// BUSY        | running the accepted transaction and any set-address it causes
//
// bus state   | meaning
// IDLE        | no transaction in flight
// SETUP       | data/rs driven, enable low
// PULSE       | enable high
// GAP         | enable low, waiting out the LCD execution time
module lcd_stream_ctrl #(
   parameter int SETUP_CYCLES   = 2,
   parameter int PULSE_CYCLES   = 4,
   parameter int GAP_CYCLES     = 40,
   parameter int CLEAR_CYCLES   = 1600,
   parameter int POWERUP_CYCLES = 15000,
   parameter int COLS           = 16,
   parameter int ROWS           = 2
) (
   input logic               clk,
   input logic               rst_n,
   lcd_stream_ctrl_if.slave  bus
);

   generate
      if (ROWS != 1 && ROWS != 2) begin : g_rows_check
         $error("lcd_stream_ctrl: ROWS must be 1 or 2");
      end
   endgenerate

   localparam int MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
   localparam int MAX_B = (GAP_CYCLES > CLEAR_CYCLES) ? GAP_CYCLES : CLEAR_CYCLES;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_T = (MAX_C > POWERUP_CYCLES) ? MAX_C : POWERUP_CYCLES;
   localparam int CW    = $clog2(MAX_T + 1);
   localparam int COLW  = (COLS > 1) ? $clog2(COLS) : 1;

   localparam logic [CW-1:0]   SETUP_LD = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0]   PULSE_LD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0]   GAP_LD   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0]   CLEAR_LD = CW'(CLEAR_CYCLES - 1);
   localparam logic [CW-1:0]   PWR_LD   = CW'(POWERUP_CYCLES - 1);
   localparam logic [COLW-1:0] COL_LAST = COLW'(COLS - 1);
   localparam logic [7:0]      FUNC_SET = (ROWS == 2) ? 8'h38 : 8'h30;

   localparam logic [1:0] TOP_POWERUP = 2'd0;
   localparam logic [1:0] TOP_INIT    = 2'd1;
   localparam logic [1:0] TOP_READY   = 2'd2;
   localparam logic [1:0] TOP_BUSY    = 2'd3;

   localparam logic [1:0] BUS_IDLE  = 2'd0;
   localparam logic [1:0] BUS_SETUP = 2'd1;
   localparam logic [1:0] BUS_PULSE = 2'd2;
   localparam logic [1:0] BUS_GAP   = 2'd3;

   logic [1:0]      top_q, top_d;
   logic [1:0]      bus_q, bus_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      init_idx_q, init_idx_d;
   logic [7:0]      data_q, data_d;
   logic            rs_q, rs_d;
   logic            en_q, en_d;
   logic            done_q, done_d;
   logic            row_q, row_d;
   logic [COLW-1:0] col_q, col_d;
   logic            pend_q, pend_d;

   logic            xact_done;
   logic            ready;
   logic            row_nxt;
   logic [7:0]      init_next_cmd;
   logic            start;
   logic [7:0]      start_data;
   logic            start_rs;

   assign xact_done = (bus_q == BUS_GAP) && (cnt_q == '0);
   // Ready already in the last gap cycle so back-to-back characters run at full rate.
   assign ready     = (top_q == TOP_READY) ||
                      ((top_q == TOP_BUSY) && xact_done && !pend_q);
   assign row_nxt   = (ROWS == 2) ? ~row_q : 1'b0;

   always_comb begin
      case (init_idx_q)
         2'd0:    init_next_cmd = 8'h0F;
         2'd1:    init_next_cmd = 8'h01;
         default: init_next_cmd = 8'h06;
      endcase
   end

   always_comb begin
      top_d      = top_q;
      bus_d      = bus_q;
      cnt_d      = cnt_q;
      init_idx_d = init_idx_q;
      data_d     = data_q;
      rs_d       = rs_q;
      en_d       = en_q;
      done_d     = done_q;
      row_d      = row_q;
      col_d      = col_q;
      pend_d     = pend_q;
      start      = 1'b0;
      start_data = 8'h00;
      start_rs   = 1'b0;

      case (bus_q)
         BUS_SETUP: begin
            if (cnt_q == '0) begin
               bus_d = BUS_PULSE;
               en_d  = 1'b1;
               cnt_d = PULSE_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         BUS_PULSE: begin
            if (cnt_q == '0) begin
               bus_d = BUS_GAP;
               en_d  = 1'b0;
               cnt_d = (data_q == 8'h01) ? CLEAR_LD : GAP_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         BUS_GAP: begin
            if (cnt_q == '0) bus_d = BUS_IDLE;
            else             cnt_d = cnt_q - CW'(1);
         end
         default: ;
      endcase

      case (top_q)
         TOP_POWERUP: begin
            if (cnt_q == '0) begin
               top_d      = TOP_INIT;
               init_idx_d = 2'd0;
               start      = 1'b1;
               start_data = FUNC_SET;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         TOP_INIT: begin
            if (xact_done) begin
               if (init_idx_q == 2'd3) begin
                  top_d  = TOP_READY;
                  done_d = 1'b1;
               end else begin
                  init_idx_d = init_idx_q + 2'd1;
                  start      = 1'b1;
                  start_data = init_next_cmd;
               end
            end
         end
         default: begin
            if ((top_q == TOP_BUSY) && xact_done && pend_q) begin
               pend_d     = 1'b0;
               start      = 1'b1;
               start_data = {1'b1, row_q, 6'b000000};
            end else if (ready && bus.clear_req) begin
               top_d      = TOP_BUSY;
               row_d      = 1'b0;
               col_d      = '0;
               pend_d     = 1'b0;
               start      = 1'b1;
               start_data = 8'h01;
            end else if (ready && bus.char_valid) begin
               top_d = TOP_BUSY;
               start = 1'b1;
               if (bus.char_data == 8'h0A) begin
                  row_d      = row_nxt;
                  col_d      = '0;
                  start_data = {1'b1, row_nxt, 6'b000000};
               end else begin
                  start_data = bus.char_data;
                  start_rs   = 1'b1;
                  if (col_q == COL_LAST) begin
                     col_d  = '0;
                     row_d  = row_nxt;
                     pend_d = 1'b1;
                  end else begin
                     col_d = col_q + COLW'(1);
                  end
               end
            end else if ((top_q == TOP_BUSY) && xact_done) begin
               top_d = TOP_READY;
            end
         end
      endcase

      if (start) begin
         data_d = start_data;
         rs_d   = start_rs;
         bus_d  = BUS_SETUP;
         cnt_d  = SETUP_LD;
         en_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q      <= TOP_POWERUP;
         bus_q      <= BUS_IDLE;
         cnt_q      <= PWR_LD;
         init_idx_q <= 2'd0;
         data_q     <= 8'h00;
         rs_q       <= 1'b0;
         en_q       <= 1'b0;
         done_q     <= 1'b0;
         row_q      <= 1'b0;
         col_q      <= '0;
         pend_q     <= 1'b0;
      end else begin
         top_q      <= top_d;
         bus_q      <= bus_d;
         cnt_q      <= cnt_d;
         init_idx_q <= init_idx_d;
         data_q     <= data_d;
         rs_q       <= rs_d;
         en_q       <= en_d;
         done_q     <= done_d;
         row_q      <= row_d;
         col_q      <= col_d;
         pend_q     <= pend_d;
      end
   end

   assign bus.char_ready = ready;
   assign bus.init_done  = done_q;
   assign bus.data       = data_q;
   assign bus.enable     = en_q;
   assign bus.rw         = 1'b0;
   assign bus.rs         = rs_q;

endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// Directed bench for lcd_stream_ctrl with small timing parameters: init
// sequence, streaming, wrap/newline/clear vectors and reset mid-transaction.
module tb_lcd_stream_ctrl;
   localparam int S = 1, P = 1, G = 2, C = 5, PW = 3, NCOLS = 4, NROWS = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lcd_stream_ctrl_if lcd_bus ();

   lcd_stream_ctrl #(
      .SETUP_CYCLES(S), .PULSE_CYCLES(P), .GAP_CYCLES(G), .CLEAR_CYCLES(C),
      .POWERUP_CYCLES(PW), .COLS(NCOLS), .ROWS(NROWS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (lcd_bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_to(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout, expected event", name);
   endtask

   // Bus write monitor: one record per enable pulse.
   typedef struct {
      logic [7:0] data;
      logic       rs;
      logic       rw;
      int         t_rise;
      int         t_fall;
   } wr_t;

   wr_t  wq[$];
   wr_t  cur;
   logic en_prev = 1'b0;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_prev = 1'b0;
      end else begin
         if (lcd_bus.enable && !en_prev) begin
            cur.data   = lcd_bus.data;
            cur.rs     = lcd_bus.rs;
            cur.rw     = lcd_bus.rw;
            cur.t_rise = cyc;
         end
         if (!lcd_bus.enable && en_prev) begin
            chk("data_stable", lcd_bus.data, cur.data);
            chk("rs_stable", lcd_bus.rs, cur.rs);
            cur.t_fall = cyc;
            wq.push_back(cur);
         end
         en_prev = lcd_bus.enable;
      end
   end

   // Called on a falling edge; returns on the falling edge after the accept edge.
   task automatic send(input logic clr, input logic vld, input logic [7:0] ch, output int acc);
      bit got;
      got = 1'b0;
      acc = -1;
      lcd_bus.clear_req  = clr;
      lcd_bus.char_valid = vld;
      lcd_bus.char_data  = ch;
      for (int k = 0; k < 200 && !got; k++) begin
         if (lcd_bus.char_ready) begin
            acc = cyc + 1;
            got = 1'b1;
         end
         @(negedge clk);
      end
      if (!got) fail_to("accept");
      else      chk("ready_drop", lcd_bus.char_ready, 1'b0);
      lcd_bus.clear_req = 1'b0;
   endtask

   task automatic drain();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         if (lcd_bus.char_ready) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) fail_to("drain");
   endtask

   // Called right after reset release on a falling edge.
   task automatic check_init();
      logic [7:0] exp_d [4];
      int         exp_r [4];
      int         done_cyc;
      logic       rdy_prev;
      wr_t        w;
      exp_d    = '{8'h38, 8'h0F, 8'h01, 8'h06};
      exp_r    = '{4, 8, 12, 19};
      done_cyc = -1;
      rdy_prev = 1'b0;
      for (int k = 0; k < 300; k++) begin
         rdy_prev = lcd_bus.char_ready;
         @(negedge clk);
         if (lcd_bus.init_done) begin
            done_cyc = cyc;
            break;
         end
      end
      if (done_cyc < 0) begin
         fail_to("init_done");
      end else begin
         chk("init_done_cycle", done_cyc, 22);
         chk("ready_with_done", lcd_bus.char_ready, 1'b1);
         chk("ready_before_done", rdy_prev, 1'b0);
         chk("init_nwrites", wq.size(), 4);
         for (int i = 0; i < 4; i++) begin
            if (wq.size() == 0) begin
               fail_to("init_write");
            end else begin
               w = wq.pop_front();
               chk("init_data", w.data, exp_d[i]);
               chk("init_rs", w.rs, 1'b0);
               chk("init_rw", w.rw, 1'b0);
               chk("init_rise", w.t_rise, exp_r[i]);
               chk("init_pulse", w.t_fall - w.t_rise, P);
            end
         end
      end
   endtask

   typedef struct {
      logic       clr;
      logic       vld;
      logic [7:0] ch;
      int         nw;
      logic [7:0] d0;
      logic       r0;
      logic [7:0] d1;
      logic       r1;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];
   int   tacc [NV];

   initial begin
      logic [7:0] hi [3];
      int         hacc [3];
      int         a;
      wr_t        w;

      lcd_bus.char_valid = 1'b0;
      lcd_bus.char_data  = 8'h00;
      lcd_bus.clear_req  = 1'b0;

      // {clr, vld, ch, nwrites, write0 data/rs, write1 data/rs}; cursor starts at (0,3)
      vecs[0]  = '{1'b1, 1'b1, 8'h5A, 1, 8'h01, 1'b0, 8'h00, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 8'h5A, 1, 8'h5A, 1'b1, 8'h00, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 8'h00, 1, 8'h01, 1'b0, 8'h00, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 8'h41, 1, 8'h41, 1'b1, 8'h00, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 8'h42, 1, 8'h42, 1'b1, 8'h00, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 8'h43, 1, 8'h43, 1'b1, 8'h00, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 8'h44, 2, 8'h44, 1'b1, 8'hC0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 8'h45, 1, 8'h45, 1'b1, 8'h00, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 8'h46, 1, 8'h46, 1'b1, 8'h00, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 8'h0A, 1, 8'h80, 1'b0, 8'h00, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 8'h78, 1, 8'h78, 1'b1, 8'h00, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 8'h79, 1, 8'h79, 1'b1, 8'h00, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 8'h7A, 1, 8'h7A, 1'b1, 8'h00, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 8'h77, 2, 8'h77, 1'b1, 8'hC0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 8'h61, 1, 8'h61, 1'b1, 8'h00, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 8'h62, 1, 8'h62, 1'b1, 8'h00, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 8'h63, 1, 8'h63, 1'b1, 8'h00, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 8'h64, 2, 8'h64, 1'b1, 8'h80, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 8'h0A, 1, 8'hC0, 1'b0, 8'h00, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_data", lcd_bus.data, 8'h00);
      chk("rst_enable", lcd_bus.enable, 1'b0);
      chk("rst_rw", lcd_bus.rw, 1'b0);
      chk("rst_rs", lcd_bus.rs, 1'b0);
      chk("rst_ready", lcd_bus.char_ready, 1'b0);
      chk("rst_done", lcd_bus.init_done, 1'b0);

      rst_n = 1'b1;
      check_init();

      // "Hi!" with valid held high
      hi = '{8'h48, 8'h69, 8'h21};
      for (int i = 0; i < 3; i++) send(1'b0, 1'b1, hi[i], hacc[i]);
      lcd_bus.char_valid = 1'b0;
      drain();
      chk("hi_spacing_1", hacc[1] - hacc[0], S + P + G);
      chk("hi_spacing_2", hacc[2] - hacc[1], S + P + G);
      for (int i = 0; i < 3; i++) begin
         if (wq.size() == 0) begin
            fail_to("hi_write");
         end else begin
            w = wq.pop_front();
            chk("hi_data", w.data, hi[i]);
            chk("hi_rs", w.rs, 1'b1);
            chk("hi_rise", w.t_rise, hacc[i] + S);
            chk("hi_pulse", w.t_fall - w.t_rise, P);
         end
      end

      for (int i = 0; i < NV; i++) send(vecs[i].clr, vecs[i].vld, vecs[i].ch, tacc[i]);
      lcd_bus.char_valid = 1'b0;
      drain();
      for (int i = 0; i < NV; i++) begin
         for (int j = 0; j < vecs[i].nw; j++) begin
            if (wq.size() == 0) begin
               fail_to("vec_write");
            end else begin
               w = wq.pop_front();
               chk($sformatf("vec%0d_data%0d", i, j), w.data, (j == 0) ? vecs[i].d0 : vecs[i].d1);
               chk($sformatf("vec%0d_rs%0d", i, j), w.rs, (j == 0) ? vecs[i].r0 : vecs[i].r1);
            end
         end
      end
      chk("vec_leftover", wq.size(), 0);
      chk("clear_gap", tacc[1] - tacc[0], S + P + C);
      chk("plain_spacing", tacc[4] - tacc[3], S + P + G);
      chk("wrap_before_E", tacc[7] - tacc[6], 2 * (S + P + G));
      chk("newline_len", tacc[10] - tacc[9], S + P + G);

      // Reset while enable is high
      send(1'b0, 1'b1, 8'h51, a);
      lcd_bus.char_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (lcd_bus.enable) break;
         @(negedge clk);
      end
      if (!lcd_bus.enable) begin
         fail_to("enable_before_reset");
      end else begin
         #2 rst_n = 1'b0;
         #1;
         chk("midrst_enable", lcd_bus.enable, 1'b0);
         chk("midrst_data", lcd_bus.data, 8'h00);
         chk("midrst_done", lcd_bus.init_done, 1'b0);
         chk("midrst_ready", lcd_bus.char_ready, 1'b0);
      end
      wq.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_init();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
